mips_trace_unit: RTL and testbench

//   Parametrised execution-trace recorder and run controller for the MIPS cores.

---
 rtl/mips_trace_unit.sv | 146 ++++++++++++++
 tb/tb_mips_trace_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_unit.sv
// mips_trace_unit: execution-trace recorder and run controller for the MIPS cores.
// Captures retired {pc, ir} pairs into a ring buffer and counts RUN cycles and
// captured instructions. Ends the run on a halt encoding, a same-PC self-loop,
// or a cycle timeout. The buffer is read back through a registered port.
module mips_trace_unit #(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     IR_W       = 32,
  parameter int unsigned     DEPTH      = 16,
  parameter int unsigned     CNT_W      = 32,
  parameter logic [IR_W-1:0] HALT_IR    = IR_W'(32'h0000000C),
  parameter int unsigned     LOOP_N     = 3,
  parameter int unsigned     MAX_CYCLES = 10000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       retire,
  input  logic [PC_W-1:0]            pc,
  input  logic [IR_W-1:0]            ir,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       rd_valid,
  output logic                       rd_miss,
  output logic [PC_W+IR_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]     entries,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           instr_cnt,
  output logic [1:0]                 state,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = AW + 1;
  localparam int unsigned DW = PC_W + IR_W;
  localparam int unsigned LW = $clog2(LOOP_N + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t          st_q;
  state_t          st_d;
  logic [AW-1:0]   wr_ptr;
  logic [PC_W-1:0] last_pc;
  logic [LW-1:0]   same_cnt;
  logic [DW-1:0]   mem [DEPTH];

  logic            run_tick;
  logic            capture;
  logic            halt_hit;
  logic            tmo_hit;
  logic [LW-1:0]   same_nxt;
  logic [AW-1:0]   rd_slot;
  logic            rd_hit;

  assign state = st_q;

  // Next-state and per-cycle control: what counts, what is captured, why the run ends
  always_comb begin
    st_d     = st_q;
    run_tick = 1'b0;
    capture  = 1'b0;
    halt_hit = 1'b0;
    tmo_hit  = 1'b0;
    same_nxt = same_cnt;
    case (st_q)
      ST_IDLE: begin
        if (en) st_d = ST_RUN;
      end
      ST_RUN: begin
        if (en) begin
          run_tick = 1'b1;
          capture  = retire;
          if (retire) begin
            // same_cnt == 0 means nothing captured yet, so the first capture counts 1
            if ((same_cnt != '0) && (pc == last_pc)) same_nxt = same_cnt + LW'(1);
            else                                     same_nxt = LW'(1);
            halt_hit = (ir == HALT_IR) || (same_nxt == LW'(LOOP_N));
          end
          tmo_hit = (MAX_CYCLES != 0) &&
                    ((cycle_cnt + CNT_W'(1)) == CNT_W'(MAX_CYCLES));
          if (halt_hit)     st_d = ST_HALTED;
          else if (tmo_hit) st_d = ST_TIMEOUT;
        end
      end
      default: begin
        st_d = st_q;
      end
    endcase
  end

  // State, counters, write pointer and loop tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      done      <= 1'b0;
      wr_ptr    <= '0;
      entries   <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      last_pc   <= '0;
      same_cnt  <= '0;
    end else begin
      st_q <= st_d;
      done <= (st_d == ST_HALTED) || (st_d == ST_TIMEOUT);
      if (run_tick) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (capture) begin
        wr_ptr    <= wr_ptr + AW'(1);
        if (entries != EW'(DEPTH)) entries <= entries + EW'(1);
        instr_cnt <= instr_cnt + CNT_W'(1);
        last_pc   <= pc;
        same_cnt  <= same_nxt;
      end
    end
  end

  // Trace storage; contents are not reset
  always_ff @(posedge clk) begin
    if (capture && !rst) mem[wr_ptr] <= {pc, ir};
  end

  // Map logical index (0 = oldest) onto the physical slot
  always_comb begin
    rd_slot = wr_ptr - entries[AW-1:0] + rd_idx;
    rd_hit  = ({1'b0, rd_idx} < entries);
  end

  // Registered read; sees the buffer before any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_miss  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_miss <= !rd_hit;
        rd_data <= rd_hit ? mem[rd_slot] : '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_trace_unit.sv
// Directed bench for mips_trace_unit with a read-result scoreboard.
module tb_mips_trace_unit;

  localparam logic [31:0] HALT = 32'h0000000C;

  logic        clk;
  logic        rst;
  logic        en;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic        rd_valid;
  logic        rd_miss;
  logic [63:0] rd_data;
  logic [4:0]  entries;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic [1:0]  state;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  mips_trace_unit #(
    .PC_W(32), .IR_W(32), .DEPTH(16), .CNT_W(32),
    .HALT_IR(32'h0000000C), .LOOP_N(3), .MAX_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .retire(retire), .pc(pc), .ir(ir),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_miss(rd_miss),
    .rd_data(rd_data), .entries(entries), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt), .state(state), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] irv(input logic [31:0] p);
    return 32'h24000000 | p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; retire = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic retire_one(input logic [31:0] p, input logic [31:0] i);
    retire = 1'b1; pc = p; ir = i;
    tick();
    retire = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] idx, input logic miss,
                         input logic [63:0] data);
    logic [64:0] e;
    exp_q.push_back({miss, data});
    rd_idx = idx; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 65'(rd_valid), 65'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, {rd_miss, rd_data}, e);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; retire = 1'b0; pc = '0; ir = '0; rd_en = 1'b0; rd_idx = '0;

    // Reset values
    do_reset();
    check("rst_state",   65'(state),     65'(0));
    check("rst_entries", 65'(entries),   65'(0));
    check("rst_cycle",   65'(cycle_cnt), 65'(0));
    check("rst_instr",   65'(instr_cnt), 65'(0));
    check("rst_done",    65'(done),      65'(0));
    check("rst_rdvalid", 65'(rd_valid),  65'(0));
    do_read("idle_read", 4'd0, 1'b1, 64'd0);

    // Five retires, then read back
    en = 1'b1;
    tick();
    check("t1_run", 65'(state), 65'(1));
    check("t1_cycle0", 65'(cycle_cnt), 65'(0));
    for (int i = 0; i < 5; i++) retire_one(32'(4 * i), irv(32'(4 * i)));
    check("t1_entries", 65'(entries),   65'(5));
    check("t1_instr",   65'(instr_cnt), 65'(5));
    check("t1_cycle",   65'(cycle_cnt), 65'(5));
    check("t1_state",   65'(state),     65'(1));
    for (int i = 0; i < 5; i++)
      do_read("t1_read", 4'(i), 1'b0, {32'(4 * i), irv(32'(4 * i))});
    do_read("t1_miss", 4'd5, 1'b1, 64'd0);
    tick();
    check("t1_valid_drop", 65'(rd_valid), 65'(0));
    check("t1_hold", {rd_miss, rd_data}, {1'b1, 64'd0});

    // Ring overflow with 20 retires
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) retire_one(32'(4 * i), irv(32'(4 * i)));
    check("t2_entries", 65'(entries),   65'(16));
    check("t2_instr",   65'(instr_cnt), 65'(20));
    do_read("t2_idx0",  4'd0,  1'b0, {32'h10, irv(32'h10)});
    do_read("t2_idx7",  4'd7,  1'b0, {32'h2C, irv(32'h2C)});
    do_read("t2_idx15", 4'd15, 1'b0, {32'h4C, irv(32'h4C)});

    // Halt instruction ends the run and is captured
    retire_one(32'h20, HALT);
    check("t3_state", 65'(state),     65'(2));
    check("t3_done",  65'(done),      65'(1));
    check("t3_instr", 65'(instr_cnt), 65'(21));
    begin
      logic [31:0] frozen;
      frozen = cycle_cnt;
      for (int i = 0; i < 3; i++) retire_one(32'(32'h100 + 4 * i), irv(32'h100));
      check("t3_instr_frozen", 65'(instr_cnt), 65'(21));
      check("t3_cycle_frozen", 65'(cycle_cnt), 65'(frozen));
      check("t3_state_hold",   65'(state),     65'(2));
    end
    do_read("t3_idx15", 4'd15, 1'b0, {32'h20, HALT});
    do_read("t3_idx0",  4'd0,  1'b0, {32'h14, irv(32'h14)});

    // Self-loop detection
    do_reset();
    en = 1'b1;
    tick();
    retire_one(32'h30, irv(32'h30));
    retire_one(32'h30, irv(32'h30));
    check("t4_second", 65'(state), 65'(1));
    retire_one(32'h30, irv(32'h30));
    check("t4_loop_halt", 65'(state),   65'(2));
    check("t4_entries",   65'(entries), 65'(3));
    do_reset();
    en = 1'b1;
    tick();
    retire_one(32'h30, irv(32'h30));
    retire_one(32'h34, irv(32'h34));
    retire_one(32'h30, irv(32'h30));
    retire_one(32'h30, irv(32'h30));
    check("t4_still_run", 65'(state),     65'(1));
    check("t4_instr",     65'(instr_cnt), 65'(4));

    // Timeout at 50 RUN cycles
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 0; i < 49; i++) tick();
    check("t5_pre_state", 65'(state),     65'(1));
    check("t5_pre_cycle", 65'(cycle_cnt), 65'(49));
    tick();
    check("t5_timeout", 65'(state),     65'(3));
    check("t5_cycle",   65'(cycle_cnt), 65'(50));
    check("t5_done",    65'(done),      65'(1));
    tick();
    tick();
    check("t5_frozen", 65'(cycle_cnt), 65'(50));

    // Halt on the timeout cycle: halt wins
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 0; i < 49; i++) tick();
    retire_one(32'h40, HALT);
    check("t5_halt_wins", 65'(state),     65'(2));
    check("t5_halt_cyc",  65'(cycle_cnt), 65'(50));
    check("t5_halt_ins",  65'(instr_cnt), 65'(1));

    // Pause, then mid-run reset
    do_reset();
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) retire_one(32'(32'h200 + 4 * i), irv(32'h200));
    check("t6_cycle_pre", 65'(cycle_cnt), 65'(3));
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      retire_one(32'h300, irv(32'h300));
      check("t6_pause_cycle", 65'(cycle_cnt), 65'(3));
    end
    check("t6_pause_instr", 65'(instr_cnt), 65'(3));
    check("t6_pause_state", 65'(state),     65'(1));
    en = 1'b1;
    tick();
    check("t6_resume", 65'(cycle_cnt), 65'(4));
    do_read("t6_read", 4'd2, 1'b0, {32'h208, irv(32'h200)});
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    check("t6_rst_state",   65'(state),     65'(0));
    check("t6_rst_cycle",   65'(cycle_cnt), 65'(0));
    check("t6_rst_instr",   65'(instr_cnt), 65'(0));
    check("t6_rst_entries", 65'(entries),   65'(0));
    check("t6_rst_done",    65'(done),      65'(0));
    check("t6_rst_rd",      {rd_valid, rd_miss, rd_data[62:0]}, 65'(0));

    check("sb_empty", 65'(exp_q.size()), 65'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
